// File: rtl/dmem_mmio_responder_if.sv
// Purpose : core data-port bus plus console TX byte stream, bundled for the responder.
// Latency : n/a (signal bundle only).
// Backpr. : n/a (tx_valid/tx_ready handshake carried here, behaviour lives in the responder).
//
// Ports (signals):
//   MemWrite, DataAdr[31:0], WriteData[31:0]  core M stage -> responder
//   ReadData[31:0]                            responder -> core (combinational)
//   tx_valid, tx_data[7:0]                    responder -> byte sink
//   tx_ready                                  byte sink -> responder
// Modports: slave = responder side, master = core + sink side.
`timescale 1ns/1ps
interface dmem_mmio_responder_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  modport slave (
    input  MemWrite, DataAdr, WriteData, tx_ready,
    output ReadData, tx_valid, tx_data
  );

  modport master (
    output MemWrite, DataAdr, WriteData, tx_ready,
    input  ReadData, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Purpose : data RAM + MMIO (console TX FIFO, status/flags, cycle counter) for the core data port.
// Latency : reads combinational (0 cycles); stores and pushes take effect next edge; push->tx_valid 1 cycle.
// Backpr. : core is never stalled; pushes into a full FIFO (no same-cycle pop) are dropped and set sticky ovf.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (RAM contents are retained)
//   bus    dmem_mmio_responder_if.slave (MemWrite/DataAdr/WriteData/ReadData, tx_valid/tx_ready/tx_data)
// Optional: define DMEM_CYCLE_CNT_EN to build the free-running 32-bit cycle counter; otherwise CYCLE reads 0.
`timescale 1ns/1ps
module dmem_mmio_responder #(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_mmio_responder_if.slave   bus
);

  localparam int unsigned     RAM_WORDS  = 1 << RAM_AW;
  localparam int unsigned     FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FIFO_FULL  = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [27:0]     MMIO_BASE  = 28'hFFFF000;
  localparam logic [1:0]      OFF_TXDATA = 2'd0;
  localparam logic [1:0]      OFF_STATUS = 2'd1;
  localparam logic [1:0]      OFF_CYCLE  = 2'd2;

  // Storage arrays: written only on enables, never reset.
  logic [31:0] ram_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        cycle_val;

  // Address decode. Byte-lane bits [1:0] are ignored: word accesses only.
  logic               ram_sel, mmio_sel;
  logic [RAM_AW-1:0]  ram_idx;
  logic [1:0]         mmio_off;
  logic               unused_adr_bits;

  assign ram_sel         = (bus.DataAdr >> (RAM_AW + 2)) == 32'd0;
  assign ram_idx         = bus.DataAdr[RAM_AW+1:2];
  assign mmio_sel        = bus.DataAdr[31:4] == MMIO_BASE;
  assign mmio_off        = bus.DataAdr[3:2];
  assign unused_adr_bits = ^bus.DataAdr[1:0];

  // FIFO control.
  logic fifo_empty, fifo_full;
  logic push_req, pop, push_ok, ovf_clr;

  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == FIFO_FULL;
  assign push_req   = bus.MemWrite && mmio_sel && (mmio_off == OFF_TXDATA);
  assign pop        = !fifo_empty && bus.tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = bus.MemWrite && mmio_sel && (mmio_off == OFF_STATUS) && bus.WriteData[2];

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Set is evaluated last so an overflow beats a simultaneous clear.
    if (ovf_clr)               ovf_d = 1'b0;
    if (push_req && !push_ok)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.MemWrite && ram_sel) ram_q[ram_idx]   <= bus.WriteData;
    if (push_ok)                 fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb cycle_d = cycle_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= 32'd0;
    else       cycle_q <= cycle_d;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = 32'd0;
`endif

  // Load path: pure function of current state, so speculative reads are harmless.
  logic [31:0] rd_data;

  always_comb begin
    rd_data = 32'd0;
    if (ram_sel) begin
      rd_data = ram_q[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_off)
        OFF_STATUS: rd_data = {27'd0, !fifo_empty, ovf_q, fifo_full, fifo_empty, 1'b0};
        OFF_CYCLE:  rd_data = cycle_val;
        default:    rd_data = 32'd0;
      endcase
    end
  end

  assign bus.ReadData = rd_data;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized + directed bench for dmem_mmio_responder with a queue-based reference model
// and a negedge monitor that checks tx_valid/tx_data every cycle and pops expected loads.
`timescale 1ns/1ps
module tb_dmem_mmio_responder;

  logic clk;
  logic reset;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder #(.RAM_AW(10), .FIFO_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int DEPTH = 8;

  // Reference model state.
  logic [31:0] mram [int];
  logic [7:0]  mfifo [$];
  logic        movf;
  logic [31:0] mcyc;
  logic [31:0] ma;

  // Scoreboard of expected load data, one entry per checked cycle.
  logic [31:0] exp_rd [$];
  logic        rd_chk;

  int n_cmp;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mmio(input logic [31:0] a);
    logic [31:0] t;
    t = a;
    return t[31:4] == 28'hFFFF000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned off;
    logic [31:0] st;
    if (a < 32'h1000) return mram[int'(a >> 2)];
    if (!is_mmio(a)) return 32'd0;
    off = (a >> 2) % 4;
    if (off == 1) begin
      st = 0;
      if (mfifo.size() != 0)     st = st + 16;
      if (movf)                  st = st + 8;
      if (mfifo.size() == DEPTH) st = st + 4;
      if (mfifo.size() == 0)     st = st + 2;
      return st;
    end
`ifdef DMEM_CYCLE_CNT_EN
    if (off == 2) return mcyc;
`endif
    return 32'd0;
  endfunction

  // Model update on each clock edge: pop first, then a push fits if room remains.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mfifo.delete();
      movf = 1'b0;
      mcyc = 32'd0;
    end else begin
      ma = bus.DataAdr;
      if (mfifo.size() != 0 && bus.tx_ready) void'(mfifo.pop_front());
      if (bus.MemWrite) begin
        if (ma < 32'h1000) begin
          mram[int'(ma >> 2)] = bus.WriteData;
        end else if (is_mmio(ma)) begin
          if (((ma >> 2) % 4) == 0) begin
            if (mfifo.size() < DEPTH) mfifo.push_back(bus.WriteData[7:0]);
            else                      movf = 1'b1;
          end else if (((ma >> 2) % 4) == 1) begin
            if (bus.WriteData[2]) movf = 1'b0;
          end
        end
      end
      mcyc = mcyc + 1;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (!reset) begin
      check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, mfifo.size() != 0});
      check("tx_data", {24'd0, bus.tx_data}, {24'd0, (mfifo.size() != 0) ? mfifo[0] : 8'h00});
      if (rd_chk) begin
        if (exp_rd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ReadData: no expected entry queued (t=%0t)", $time);
        end else begin
          check("ReadData", bus.ReadData, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic chk);
    @(posedge clk);
    #1;
    bus.MemWrite  = we;
    bus.DataAdr   = a;
    bus.WriteData = d;
    bus.tx_ready  = rdy;
    rd_chk        = chk;
    if (chk) exp_rd.push_back(ref_read(a));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned w;
    case ($urandom_range(0, 5))
      0, 1: begin
        w = ($urandom_range(0, 16) == 16) ? 1023 : $urandom_range(0, 15);
        a = (w * 4) + $urandom_range(0, 3);
      end
      2, 3, 4: a = 32'hFFFF0000 + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
      default: begin
        a = $urandom;
        if (a < 32'h1000 || is_mmio(a)) a = 32'h0000_1000 + $urandom_range(0, 3);
      end
    endcase
    return a;
  endfunction

  task automatic reset_mid(input int word);
    logic [31:0] keep;
    keep = mram[word];
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    bus.tx_ready = 1'b0;
    bus.DataAdr  = 32'hFFFF0004;
    rd_chk       = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_status", bus.ReadData, 32'h0000_0002);
    bus.DataAdr = 32'hFFFF0008;
    #1;
    check("rst_cycle", bus.ReadData, 32'd0);
    bus.DataAdr = word * 4;
    #1;
    check("rst_ram_keep", bus.ReadData, keep);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rd_chk = 1'b0;
    reset = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'd0;
    bus.WriteData = 32'd0;
    bus.tx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;

    // Post-reset status, then seed RAM words so every later load is defined.
    cyc(0, 32'hFFFF0004, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, i * 4, $urandom, 0, 0);
    cyc(1, 1023 * 4, $urandom, 0, 0);

    // RAM: same-cycle write returns old data, ignored byte bits, neighbour untouched.
    cyc(1, 32'h10, 32'hDEADBEEF, 0, 1);
    cyc(0, 32'h10, 0, 0, 1);
    cyc(0, 32'h13, 0, 0, 1);
    cyc(0, 32'h14, 0, 0, 1);

    // Fill FIFO, overflow, then drain in order.
    for (int i = 0; i < 8; i++) cyc(1, 32'hFFFF0000, 32'h41 + i, 0, 1);
    cyc(0, 32'hFFFF0004, 0, 0, 1);
    cyc(1, 32'hFFFF0000, 32'h49, 0, 1);
    cyc(0, 32'hFFFF0004, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 32'hFFFF0004, 0, 1, 1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cyc(1, 32'hFFFF0000, 32'h61 + i, 0, 1);
    cyc(1, 32'hFFFF0000, 32'h5A, 1, 1);
    cyc(0, 32'hFFFF0004, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 32'hFFFF0004, 0, 1, 1);

    // ovf clear: bit 2 clear only.
    cyc(1, 32'hFFFF0004, 32'hFFFF_FFFB, 0, 1);
    cyc(0, 32'hFFFF0004, 0, 0, 1);
    cyc(1, 32'hFFFF0004, 32'h4, 0, 1);
    cyc(0, 32'hFFFF0004, 0, 0, 1);

    // Cycle register, writes ignored; reserved and unmapped.
    cyc(0, 32'hFFFF0008, 0, 0, 1);
    cyc(1, 32'hFFFF0008, 32'h1234_5678, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 32'h0000_0020, 0, 0, 1);
    cyc(0, 32'hFFFF0008, 0, 0, 1);
    cyc(1, 32'hFFFF000C, 32'hFFFF_FFFF, 0, 1);
    cyc(0, 32'hFFFF000C, 0, 0, 1);
    cyc(1, 32'h0000_1000, 32'hCAFE_F00D, 0, 1);
    cyc(0, 32'h0000_0000, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      a = rand_addr();
      cyc(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, a,
          ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h4),
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 1'b1);
    end

    // Reset mid-drain with three bytes held.
    for (int i = 0; i < 10; i++) cyc(0, 32'hFFFF0004, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 32'hFFFF0000, 32'h71 + i, 0, 1);
    reset_mid(4);
    cyc(0, 32'hFFFF0004, 0, 0, 1);
    cyc(0, 32'h10, 0, 0, 1);

    for (int i = 0; i < 100; i++) cyc(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, rand_addr(),
                                      $urandom, $urandom_range(0, 1) == 1, 1'b1);
    for (int i = 0; i < 12; i++) cyc(0, 32'hFFFF0004, 0, 1, 1);
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", exp_rd.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
